// File: rtl/prm_edge_pkg.sv
// rtl/prm_edge_pkg.sv - shared constants and FSM encodings for the edge mask accumulator
package prm_edge_pkg;

    localparam int CODE_W        = 15;
    localparam int NUM_EDGES_DEF = 1024;
    localparam int WORD_W_DEF    = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // A single-word bitmap still needs a 1-bit index port.
    function automatic int idx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/prm_edge_word_ser.sv
// rtl/prm_edge_word_ser.sv - bitmap word index counter and output valid/ready handshake
module prm_edge_word_ser
    import prm_edge_pkg::*;
#(
    parameter int NWORDS = 32,
    parameter int IDX_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_out_last,
    output logic             o_fin
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    logic             r_valid;
    logic             r_last;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_xfer;

    assign w_xfer    = r_valid & i_out_ready;
    assign w_idx_nxt = r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_last  <= (LAST_IDX == '0);
        end else if (w_xfer) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_idx   <= '0;
                r_last  <= 1'b0;
            end else begin
                r_idx  <= w_idx_nxt;
                r_last <= (w_idx_nxt == LAST_IDX);
            end
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_idx   = r_idx;
    assign o_out_last  = r_last;
    assign o_fin       = w_xfer & r_last;

endmodule

// File: rtl/prm_edge_mask_accum.sv
// rtl/prm_edge_mask_accum.sv - streams obstacle codes into the checker bank, ORs edge masks, reads bitmap out
module prm_edge_mask_accum
    import prm_edge_pkg::*;
#(
    parameter int NUM_EDGES = NUM_EDGES_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    localparam int NWORDS   = NUM_EDGES / WORD_W,
    localparam int IDX_W    = idx_w(NUM_EDGES / WORD_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [CODE_W-1:0]    obs_code,
    input  logic                 obs_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          n_samples
);

    if (NUM_EDGES % WORD_W != 0) begin : g_bad_word_w
        $error("NUM_EDGES must be a multiple of WORD_W");
    end

    logic [1:0]           r_state;
    logic [CODE_W-1:0]    r_chk_code;
    logic                 r_stage_vld;
    logic [NUM_EDGES-1:0] r_blocked;
    logic [15:0]          r_n_samples;
    logic                 r_done;
    logic                 w_acc;
    logic                 w_start_ok;
    logic                 w_fin;
    logic [WORD_W-1:0]    w_out_data;
    logic [IDX_W-1:0]     w_out_idx;

    assign obs_ready  = (r_state == ST_SCAN);
    assign w_acc      = obs_valid & obs_ready;
    assign w_start_ok = start & (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fin;
            case (r_state)
                ST_IDLE:  if (start) r_state <= ST_SCAN;
                ST_SCAN:  if (w_acc && obs_last) r_state <= ST_FLUSH;
                ST_FLUSH: r_state <= ST_DRAIN;
                ST_DRAIN: if (w_fin) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // The mask returned for a code is folded one cycle after the code is registered;
    // stage-valid keeps a held code from being folded again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_code  <= '0;
            r_stage_vld <= 1'b0;
            r_blocked   <= '0;
            r_n_samples <= '0;
        end else begin
            r_stage_vld <= w_acc;
            if (w_acc) r_chk_code <= obs_code;
            if (w_start_ok) r_blocked <= '0;
            else if (r_stage_vld) r_blocked <= r_blocked | chk_mask;
            if (w_start_ok) r_n_samples <= '0;
            else if (w_acc && r_n_samples != 16'hFFFF) r_n_samples <= r_n_samples + 16'd1;
        end
    end

    prm_edge_word_ser #(
        .NWORDS (NWORDS),
        .IDX_W  (IDX_W)
    ) u_word_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (r_state == ST_FLUSH),
        .i_out_ready (out_ready),
        .o_out_valid (out_valid),
        .o_out_idx   (w_out_idx),
        .o_out_last  (out_last),
        .o_fin       (w_fin)
    );

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (w_out_idx == IDX_W'(i)) w_out_data = r_blocked[i*WORD_W +: WORD_W];
        end
    end

    assign chk_code  = r_chk_code;
    assign out_data  = w_out_data;
    assign out_idx   = w_out_idx;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign n_samples = r_n_samples;

endmodule
